asym_ram_burst_reader: RTL and testbench

//  Downstream read engine for the asymmetric true-dual-port RAM's wide port (port A).
//  On a start command it issues a burst of sequential reads, absorbs the RAM's fixed
//  2-cycle read latency (registered address plus registered data), and presents the

---
 rtl/asym_ram_burst_reader.sv | 142 ++++++++++++++
 tb/tb_asym_ram_burst_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_ram_burst_reader.sv
// Burst read engine for the wide port of the asymmetric dual-port RAM; streams words out as valid/ready.
// Optional abort input is compiled in when ASYM_RD_ABORT_EN is defined.
module asym_ram_burst_reader #(
  parameter int DW     = 16,
  parameter int AW     = 8,
  parameter int RD_LAT = 2,
  parameter int BUF_D  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
`ifdef ASYM_RD_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam int PW = $clog2(BUF_D);
  localparam int CW = $clog2(BUF_D + 1);
  localparam logic [AW:0]  ONE_L   = 1;
  localparam logic [CW:0]  DEPTH_C = (CW + 1)'(BUF_D);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [AW:0]       issue_left;
  logic [AW:0]       out_left;
  logic [RD_LAT-1:0] vld_p;
  logic [CW-1:0]     in_flight;
  logic [CW-1:0]     buf_count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DW-1:0]     buf_mem [BUF_D];
  logic              done_r;
  logic              abort_hit;

  logic [CW:0] credit_sum;
  logic        issue;
  logic        capture;
  logic        pop;

`ifdef ASYM_RD_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Credit covers every read already issued plus every word buffered, so the buffer cannot overflow.
  assign credit_sum = {1'b0, in_flight} + {1'b0, buf_count};
  assign issue      = (state == ISSUE) && (credit_sum < DEPTH_C);
  assign capture    = vld_p[RD_LAT-1];
  assign pop        = m_valid && m_ready;

  assign busy    = (state != IDLE);
  assign done    = done_r;
  assign ram_we  = 1'b0;
  assign m_valid = (buf_count != '0);
  assign m_data  = m_valid ? buf_mem[rd_ptr] : '0;
  assign m_last  = m_valid && (out_left == ONE_L);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      issue_left <= '0;
      out_left   <= '0;
      vld_p      <= '0;
      in_flight  <= '0;
      buf_count  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_addr   <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort_hit) begin
        state     <= IDLE;
        vld_p     <= '0;
        in_flight <= '0;
        buf_count <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        done_r    <= 1'b1;
      end else begin
        // Read tag pipeline: a tag leaving the last stage marks ram_dout as valid this cycle.
        vld_p     <= (vld_p << 1) | RD_LAT'(issue);
        in_flight <= in_flight + CW'(issue) - CW'(capture);
        buf_count <= buf_count + CW'(capture) - CW'(pop);
        if (capture) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          out_left <= out_left - 1'b1;
        end
        case (state)
          IDLE: begin
            if (start) begin
              if (len != '0) begin
                state      <= ISSUE;
                ram_addr   <= base_addr;
                issue_left <= len;
                out_left   <= len;
              end else begin
                done_r <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (issue) begin
              ram_addr   <= ram_addr + 1'b1;
              issue_left <= issue_left - 1'b1;
              if (issue_left == ONE_L) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (pop && (out_left == ONE_L)) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) buf_mem[wr_ptr] <= ram_dout;
  end

endmodule

// File: tb/tb_asym_ram_burst_reader.sv
// Directed bench for asym_ram_burst_reader with a 2-cycle RAM model holding mem[i]=i*3.
module tb_asym_ram_burst_reader;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef ASYM_RD_ABORT_EN
  logic          abort;
`endif

  always #5 clk = ~clk;

  asym_ram_burst_reader #(.DW(DW), .AW(AW), .RD_LAT(2), .BUF_D(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef ASYM_RD_ABORT_EN
    , .abort(abort)
`endif
  );

  // RAM port A: registered address then registered data
  logic [DW-1:0] mem [256];
  logic [DW-1:0] r1;
  always @(posedge clk) begin
    r1       <= mem[ram_addr];
    ram_dout <= r1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]        base;
    logic [8:0]        len;
    logic [3:0]        pat;
    bit                poke;
    logic [0:7][15:0]  exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},    busy,     0);
    chk({tag, "_done"},    done,     0);
    chk({tag, "_valid"},   m_valid,  0);
    chk({tag, "_last"},    m_last,   0);
    chk({tag, "_data"},    m_data,   0);
    chk({tag, "_addr"},    ram_addr, 0);
  endtask

  task automatic run_burst(input int vi);
    vec_t v;
    int n, k, first_k, max_out, iss;
    logic pv, pr, pl;
    logic [15:0] pd;
    v = vecs[vi];
    n = 0; k = 0; first_k = -1; max_out = 0;
    pv = 0; pr = 0; pl = 0; pd = '0;
    @(negedge clk);
    chk("idle_before_start", busy, 0);
    start = 1; base_addr = v.base; len = v.len; m_ready = 0;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    while (n < int'(v.len) && k < 600) begin
      if (pv && !pr) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, pd);
        chk("stall_last", m_last, pl);
      end
      if (m_valid && first_k < 0) first_k = k;
      iss = int'(8'(ram_addr - v.base));
      if (iss - n > max_out) max_out = iss - n;
      m_ready = v.pat[k % 4];
      if (v.poke && k == 2) begin
        start = 1; base_addr = 8'h80; len = 9'd2;
      end else begin
        start = 0;
      end
      if (m_valid && m_ready) begin
        chk($sformatf("v%0d_data%0d", vi, n), m_data, v.exp[n]);
        chk($sformatf("v%0d_last%0d", vi, n), m_last, (n == int'(v.len) - 1));
        n++;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      @(negedge clk);
      k++;
    end
    start = 0;
    m_ready = 0;
    chk($sformatf("v%0d_complete", vi), n, v.len);
    chk($sformatf("v%0d_first_valid_lat", vi), first_k, 3);
    chk($sformatf("v%0d_credit_le4", vi), (max_out <= 4), 1);
    chk($sformatf("v%0d_done_pulse", vi), done, 1);
    chk($sformatf("v%0d_busy_clear", vi), busy, 0);
    chk($sformatf("v%0d_valid_clear", vi), m_valid, 0);
    @(negedge clk);
    chk($sformatf("v%0d_done_single", vi), done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k, derr, lerr;
    for (int i = 0; i < 256; i++) mem[i] = DW'(i * 3);

    vecs[0] = '{base: 8'h10, len: 9'd4, pat: 4'b1111, poke: 0,
                exp: {16'h030, 16'h033, 16'h036, 16'h039, 16'h0, 16'h0, 16'h0, 16'h0}};
    vecs[1] = '{base: 8'hFE, len: 9'd4, pat: 4'b1111, poke: 0,
                exp: {16'h2FA, 16'h2FD, 16'h000, 16'h003, 16'h0, 16'h0, 16'h0, 16'h0}};
    vecs[2] = '{base: 8'h20, len: 9'd8, pat: 4'b1001, poke: 0,
                exp: {16'h060, 16'h063, 16'h066, 16'h069, 16'h06C, 16'h06F, 16'h072, 16'h075}};
    vecs[3] = '{base: 8'h05, len: 9'd1, pat: 4'b1111, poke: 0,
                exp: {16'h00F, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
    vecs[4] = '{base: 8'h40, len: 9'd3, pat: 4'b0101, poke: 1,
                exp: {16'h0C0, 16'h0C3, 16'h0C6, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};

    rst_n = 0; start = 0; m_ready = 0; base_addr = '0; len = '0;
`ifdef ASYM_RD_ABORT_EN
    abort = 0;
`endif
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_we", ram_we, 0);
    rst_n = 1;

    for (int i = 0; i < 5; i++) run_burst(i);

    // Zero-length command
    @(negedge clk);
    start = 1; base_addr = 8'h33; len = 9'd0;
    @(negedge clk);
    start = 0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_valid", m_valid, 0);
    @(negedge clk);
    chk("len0_done_single", done, 0);
    chk("len0_busy_after", busy, 0);

    // Reset in the middle of a burst
    @(negedge clk);
    start = 1; base_addr = 8'h30; len = 9'd8;
    @(negedge clk);
    start = 0; m_ready = 1; n = 0; k = 0;
    while (n < 2 && k < 50) begin
      if (m_valid) n++;
      @(negedge clk);
      k++;
    end
    chk("midrst_two_words", n, 2);
    rst_n = 0; m_ready = 0;
    @(negedge clk);
    rst_n = 1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done, 0);
    chk("midrst_no_valid", m_valid, 0);
    run_burst(0);

    // Full address space burst wrapping past the top
    @(negedge clk);
    start = 1; base_addr = 8'h80; len = 9'd256;
    @(negedge clk);
    start = 0; m_ready = 1; n = 0; k = 0; derr = 0; lerr = 0;
    while (n < 256 && k < 1000) begin
      if (m_valid) begin
        if (m_data !== DW'(((8'h80 + n) % 256) * 3)) derr++;
        if (m_last !== (n == 255)) lerr++;
        n++;
      end
      @(negedge clk);
      k++;
    end
    m_ready = 0;
    chk("full_count", n, 256);
    chk("full_data_errs", derr, 0);
    chk("full_last_errs", lerr, 0);
    chk("full_done", done, 1);
    chk("full_busy", busy, 0);

`ifdef ASYM_RD_ABORT_EN
    // Abort after three handshakes
    @(negedge clk);
    start = 1; base_addr = 8'h00; len = 9'd16;
    @(negedge clk);
    start = 0; m_ready = 1; n = 0; k = 0; lerr = 0;
    while (n < 3 && k < 50) begin
      if (m_valid) begin
        if (m_last) lerr++;
        n++;
      end
      @(negedge clk);
      k++;
    end
    chk("abort_three_words", n, 3);
    abort = 1; m_ready = 0;
    @(negedge clk);
    abort = 0;
    chk("abort_valid", m_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    chk("abort_last", m_last, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || m_valid || m_last || busy) n++;
    end
    chk("abort_quiet_after", n, 0);
    chk("abort_no_last_before", lerr, 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_idle_no_done", done, 0);
    run_burst(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
